// File: rtl/cnt_seq_monitor.sv
// cnt_seq_monitor: downstream checker for an up/down counter.
// Samples count_in every clock and checks each sample against the previous
// sample +/-1, following the expected direction. It locks after LOCK_LEN
// consecutive good steps. While locked it counts wraps, reports restarts to 0,
// and flags any other mismatch as a sequence error. Every output is registered.
module cnt_seq_monitor #(
   parameter int CNT_W    = 4,
   parameter int WRAP_W   = 8,
   parameter int ERR_W    = 4,
   parameter int LOCK_LEN = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  count_in,
   input  logic              dir,
   input  logic              clr_err,
   output logic              locked,
   output logic              wrap_pulse,
   output logic              restart_pulse,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              err_pulse,
   output logic              err_sticky,
   output logic [ERR_W-1:0]  err_cnt
);

   typedef enum logic [1:0] {IDLE, SYNC, TRACK} state_e;

   localparam int                RUN_W    = 3;
   localparam logic [RUN_W-1:0]  LOCK_RUN = RUN_W'(LOCK_LEN);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   prev_q;
   logic [RUN_W-1:0]   run_q, run_d, run_inc;
   logic               dir_q;
   logic               locked_q, locked_d;
   logic               wrap_pulse_q, wrap_pulse_d;
   logic               restart_pulse_q, restart_pulse_d;
   logic               err_pulse_q, err_pulse_d;
   logic [WRAP_W-1:0]  wrap_cnt_q, wrap_cnt_d;
   logic               err_sticky_q, err_sticky_d;
   logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

   logic [CNT_W-1:0]   exp_val;
   logic               step_ok;
   logic               is_wrap;
   logic               dir_chg;

   // Next-state and output decode: classify the current sample against the expected step.
   always_comb begin
      // NOTE: every variable gets a default before the case; a path that leaves one unassigned would infer a latch.
      state_d         = state_q;
      run_d           = run_q;
      wrap_pulse_d    = 1'b0;
      restart_pulse_d = 1'b0;
      err_pulse_d     = 1'b0;
      wrap_cnt_d      = wrap_cnt_q;
      err_sticky_d    = clr_err ? 1'b0 : err_sticky_q;
      err_cnt_d       = clr_err ? '0 : err_cnt_q;

      exp_val = dir_q ? (prev_q - 1'b1) : (prev_q + 1'b1);
      step_ok = (count_in == exp_val);
      is_wrap = dir_q ? (prev_q == '0 && count_in == CNT_MAX)
                      : (prev_q == CNT_MAX && count_in == '0);
      dir_chg = (dir != dir_q);
      run_inc = run_q + 1'b1;

      case (state_q)
         IDLE: begin
            run_d   = '0;
            state_d = SYNC;
         end
         SYNC: begin
            if (step_ok) begin
               run_d = run_inc;
               if (run_inc >= LOCK_RUN) state_d = TRACK;
            end else begin
               run_d = '0;
            end
         end
         TRACK: begin
            if (step_ok) begin
               if (is_wrap) begin
                  wrap_pulse_d = 1'b1;
                  wrap_cnt_d   = wrap_cnt_q + 1'b1;
               end
            end else begin
               run_d   = '0;
               state_d = SYNC;
               // A mismatch in the cycle that dir changes is blamed on the direction change and not reported.
               if (!dir_chg) begin
                  if (count_in == '0) begin
                     restart_pulse_d = 1'b1;
                  end else begin
                     err_pulse_d  = 1'b1;
                     err_sticky_d = 1'b1;
                     if (err_cnt_d != ERR_MAX) err_cnt_d = err_cnt_d + 1'b1;
                  end
               end
            end
         end
         default: begin
            run_d   = '0;
            state_d = IDLE;
         end
      endcase

      // A direction change forces resynchronisation in the new direction.
      if (dir_chg) begin
         run_d   = '0;
         state_d = SYNC;
      end

      locked_d = (state_d == TRACK);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q         <= IDLE;
         prev_q          <= '0;
         run_q           <= '0;
         dir_q           <= dir;
         locked_q        <= 1'b0;
         wrap_pulse_q    <= 1'b0;
         restart_pulse_q <= 1'b0;
         err_pulse_q     <= 1'b0;
         wrap_cnt_q      <= '0;
         err_sticky_q    <= 1'b0;
         err_cnt_q       <= '0;
      end else begin
         state_q         <= state_d;
         prev_q          <= count_in;
         run_q           <= run_d;
         dir_q           <= dir;
         locked_q        <= locked_d;
         wrap_pulse_q    <= wrap_pulse_d;
         restart_pulse_q <= restart_pulse_d;
         err_pulse_q     <= err_pulse_d;
         wrap_cnt_q      <= wrap_cnt_d;
         err_sticky_q    <= err_sticky_d;
         err_cnt_q       <= err_cnt_d;
      end
   end

   assign locked        = locked_q;
   assign wrap_pulse    = wrap_pulse_q;
   assign restart_pulse = restart_pulse_q;
   assign wrap_cnt      = wrap_cnt_q;
   assign err_pulse     = err_pulse_q;
   assign err_sticky    = err_sticky_q;
   assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Self-checking bench for cnt_seq_monitor: directed scenarios followed by random
// stimulus. Every cycle is compared against a rule-level reference model.
module tb_cnt_seq_monitor;

   localparam int LOCK_LEN = 2;

   logic       clk;
   logic       rst;
   logic [3:0] count_in;
   logic       dir;
   logic       clr_err;
   logic       locked;
   logic       wrap_pulse;
   logic       restart_pulse;
   logic [7:0] wrap_cnt;
   logic       err_pulse;
   logic       err_sticky;
   logic [3:0] err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_prev, m_fresh, m_locked, m_streak;
   bit m_dir;
   int e_wrap, e_restart, e_err, e_wcnt, e_sticky, e_ecnt;

   // Stimulus counter emulation
   int cv;
   bit dv;

   cnt_seq_monitor #(.CNT_W(4), .WRAP_W(8), .ERR_W(4), .LOCK_LEN(LOCK_LEN)) dut (
      .clk           (clk),
      .rst           (rst),
      .count_in      (count_in),
      .dir           (dir),
      .clr_err       (clr_err),
      .locked        (locked),
      .wrap_pulse    (wrap_pulse),
      .restart_pulse (restart_pulse),
      .wrap_cnt      (wrap_cnt),
      .err_pulse     (err_pulse),
      .err_sticky    (err_sticky),
      .err_cnt       (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Rule-level model: one call per clock edge with the inputs sampled at that edge.
   task automatic model(input int c, input bit d, input bit clr, input bit r);
      int nxt;
      bit good;
      bit wrap;
      e_wrap = 0; e_restart = 0; e_err = 0;
      if (r) begin
         m_prev = 0; m_dir = d; m_fresh = 1; m_locked = 0; m_streak = 0;
         e_wcnt = 0; e_sticky = 0; e_ecnt = 0;
         return;
      end
      if (clr) begin
         e_sticky = 0;
         e_ecnt   = 0;
      end
      nxt  = m_dir ? (m_prev + 15) % 16 : (m_prev + 1) % 16;
      good = (c == nxt);
      wrap = good && (m_dir ? (m_prev == 0) : (m_prev == 15));
      if (m_fresh != 0) begin
         m_fresh  = 0;
         m_streak = 0;
      end else if (m_locked != 0) begin
         if (good) begin
            if (wrap) begin
               e_wrap = 1;
               e_wcnt = (e_wcnt + 1) % 256;
            end
         end else begin
            m_locked = 0;
            m_streak = 0;
            if (d == m_dir) begin
               if (c == 0) begin
                  e_restart = 1;
               end else begin
                  e_err    = 1;
                  e_sticky = 1;
                  if (e_ecnt < 15) e_ecnt++;
               end
            end
         end
      end else begin
         m_streak = good ? m_streak + 1 : 0;
         if (m_streak >= LOCK_LEN) m_locked = 1;
      end
      if (d != m_dir) begin
         m_locked = 0;
         m_streak = 0;
      end
      m_prev = c;
      m_dir  = d;
   endtask

   // Apply one cycle of inputs, advance the model, compare every output.
   task automatic step(input int c, input bit d, input bit clr, input bit r);
      count_in = 4'(c);
      dir      = d;
      clr_err  = clr;
      rst      = r;
      @(posedge clk);
      #1;
      model(c, d, clr, r);
      check("locked",        32'(locked),        m_locked);
      check("wrap_pulse",    32'(wrap_pulse),    e_wrap);
      check("restart_pulse", 32'(restart_pulse), e_restart);
      check("wrap_cnt",      32'(wrap_cnt),      e_wcnt);
      check("err_pulse",     32'(err_pulse),     e_err);
      check("err_sticky",    32'(err_sticky),    e_sticky);
      check("err_cnt",       32'(err_cnt),       e_ecnt);
      check("pulse_excl", 32'($countones({wrap_pulse, restart_pulse, err_pulse}) <= 1), 1);
   endtask

   task automatic good_steps(input int n);
      for (int i = 0; i < n; i++) begin
         step(cv, dv, 1'b0, 1'b0);
         cv = dv ? (cv + 15) % 16 : (cv + 1) % 16;
      end
   endtask

   initial begin
      int sel;
      int bad;
      bit clr;
      rst = 1'b1; count_in = '0; dir = 1'b0; clr_err = 1'b0;
      cv = 0; dv = 1'b0;

      // Reset for 5 clocks
      for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b0, 1'b1);
      check("rst_locked",  32'(locked),   0);
      check("rst_wrapcnt", 32'(wrap_cnt), 0);
      check("rst_errcnt",  32'(err_cnt),  0);

      // Basic lock and wraps
      good_steps(3);
      check("lock_by_4th", 32'(locked), 1);
      good_steps(31);
      check("wrap_cnt_2", 32'(wrap_cnt), 2);
      check("no_err",     32'(err_cnt),  0);

      // Restart at count 9
      good_steps(8);
      cv = 0;
      good_steps(1);
      check("restart_pulse_hi", 32'(restart_pulse), 1);
      check("restart_unlock",   32'(locked),        0);
      check("restart_no_err",   32'(err_sticky),    0);
      good_steps(1);
      check("restart_pulse_1cyc", 32'(restart_pulse), 0);
      good_steps(1);
      check("restart_relock", 32'(locked), 1);

      // Hold at 5 for 2 cycles, then skip 7 -> 10
      good_steps(3);
      step(5, dv, 1'b0, 1'b0);
      check("hold_err", 32'(err_pulse), 1);
      check("hold_unlock", 32'(locked), 0);
      step(5, dv, 1'b0, 1'b0);
      check("hold_err_once", 32'(err_pulse), 0);
      good_steps(2);
      check("hold_relock", 32'(locked), 1);
      cv = 10;
      good_steps(1);
      check("skip_err", 32'(err_pulse), 1);
      good_steps(2);
      check("skip_relock", 32'(locked),     1);
      check("err_cnt_2",   32'(err_cnt),    2);
      check("err_sticky",  32'(err_sticky), 1);

      // Down mode with direction change mid-run
      dv = 1'b1;
      good_steps(1);
      check("dirchg_no_err", 32'(err_pulse), 0);
      check("dirchg_unlock", 32'(locked),    0);
      cv = 12;
      good_steps(2);
      check("down_lock", 32'(locked), 1);
      good_steps(13);
      check("down_wrap_cnt", 32'(wrap_cnt), 3);
      dv = 1'b0;
      cv = 15;
      good_steps(1);
      check("dirback_no_err", 32'(err_pulse), 0);
      good_steps(2);
      check("dirback_relock", 32'(locked),   1);
      check("dirback_errcnt", 32'(err_cnt),  2);

      // Reset mid-operation with wrap_cnt=3
      step(cv, dv, 1'b0, 1'b1);
      check("midrst_locked",  32'(locked),     0);
      check("midrst_wrapcnt", 32'(wrap_cnt),   0);
      check("midrst_sticky",  32'(err_sticky), 0);
      step(cv, dv, 1'b0, 1'b1);
      cv = 0;
      good_steps(2);
      check("midrst_hold_unlocked", 32'(locked), 0);
      good_steps(1);
      check("midrst_relock", 32'(locked), 1);

      // 20 errors: saturation, then clear, then clear coincident with an error
      for (int k = 0; k < 20; k++) begin
         bad = (cv + 2) % 16;
         if (bad == 0) bad = (cv + 3) % 16;
         step(bad, dv, 1'b0, 1'b0);
         cv = (bad + 1) % 16;
         good_steps(2);
      end
      check("err_sat", 32'(err_cnt), 15);
      step(cv, dv, 1'b1, 1'b0);
      cv = (cv + 1) % 16;
      check("clr_cnt",    32'(err_cnt),    0);
      check("clr_sticky", 32'(err_sticky), 0);
      bad = (cv + 2) % 16;
      if (bad == 0) bad = (cv + 3) % 16;
      step(bad, dv, 1'b1, 1'b0);
      check("clr_vs_err_cnt",    32'(err_cnt),    1);
      check("clr_vs_err_sticky", 32'(err_sticky), 1);
      cv = (bad + 1) % 16;
      good_steps(2);

      // Randomized mix of steps, holds, jumps, restarts, dir toggles, clears, resets
      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(99));
         clr = ($urandom_range(9) == 0);
         if (sel < 2) begin
            step(cv, dv, clr, 1'b1);
            cv = dv ? (cv + 15) % 16 : (cv + 1) % 16;
         end else if (sel < 10) begin
            step(dv ? (cv + 1) % 16 : (cv + 15) % 16, dv, clr, 1'b0);
         end else if (sel < 18) begin
            bad = int'($urandom_range(15));
            step(bad, dv, clr, 1'b0);
            cv = dv ? (bad + 15) % 16 : (bad + 1) % 16;
         end else if (sel < 23) begin
            step(0, dv, clr, 1'b0);
            cv = dv ? 15 : 1;
         end else if (sel < 28) begin
            dv = ~dv;
            step(cv, dv, clr, 1'b0);
            cv = dv ? (cv + 15) % 16 : (cv + 1) % 16;
         end else begin
            step(cv, dv, clr, 1'b0);
            cv = dv ? (cv + 15) % 16 : (cv + 1) % 16;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cnt_seq_monitor.md
Name: cnt_seq_monitor

Overview:
- Downstream checker for the 4-bit synchronous up/down counter.
- Samples the counter's `count` output every clock and checks that it steps by exactly ±1 modulo 2^CNT_W.
- Counts wrap-arounds, detects counter restarts (return to 0), and flags sequence errors.
- Drives status to the lab's LED/debug layer.

Parameters:
- CNT_W, 4, width of monitored count.
- WRAP_W, 8, width of wrap counter.
- ERR_W, 4, width of error counter.
- LOCK_LEN, 2, consecutive correct steps required to enter TRACK (1..7).

Ports:
- clk  input  1  rising-edge clock, shared with counter.
- rst  input  1  synchronous, active-high reset.
- count_in  input  CNT_W  counter output under test.
- dir  input  1  expected direction: 0 = up, 1 = down.
- clr_err  input  1  clears err_sticky and err_cnt.
- locked  output  1  high while in TRACK.
- wrap_pulse  output  1  one-cycle pulse per detected wrap.
- restart_pulse  output  1  one-cycle pulse per detected restart.
- wrap_cnt  output  WRAP_W  wraps seen since reset; wraps modulo 2^WRAP_W.
- err_pulse  output  1  one-cycle pulse per sequence error.
- err_sticky  output  1  set on any error; held until clr_err or rst.
- err_cnt  output  ERR_W  errors seen; saturates at all-ones.

Behaviour:
- Reset and timing:
  - Clock is clk. Reset is synchronous and active-high on rst.
  - On rst: state=IDLE, prev=0, run=0, dir_q=dir. All outputs are 0.
  - All outputs are registered.
  - The decision for the sample taken at edge N is visible after edge N: latency 1 clock from count_in change to status.
- Expected next value:
  - exp = prev+1 mod 2^CNT_W when dir_q=0.
  - exp = prev−1 mod 2^CNT_W when dir_q=1.
- Wrap detection:
  - Up: prev=MAX and count_in=0.
  - Down: prev=0 and count_in=MAX.
- FSM:
  - IDLE:
    - Capture prev=count_in and set run=0.
    - Go to SYNC next cycle.
    - No pulses are generated.
  - SYNC:
    - count_in==exp: run++. If run reaches LOCK_LEN, go to TRACK.
    - Otherwise: run=0.
    - No errors, wraps or restarts are reported in SYNC.
    - Wrap steps still count toward run.
  - TRACK:
    - count_in==exp: stay in TRACK. If the step is a wrap: wrap_pulse=1 and wrap_cnt++.
    - count_in==0 and count_in!=exp: restart. Set restart_pulse=1, run=0, go to SYNC. No error.
    - Any other mismatch, including a hold (count_in==prev≠0): err_pulse=1, err_sticky=1, err_cnt++ (saturating), run=0, go to SYNC.
  - prev<=count_in every cycle in every state except during rst.
- Direction change:
  - dir is registered into dir_q each cycle.
  - If dir≠dir_q, go to SYNC with run=0 and no error reported; comparison that cycle uses the old dir_q.
- clr_err:
  - Clears err_sticky and err_cnt at the edge.
  - If an error occurs in the same cycle, the error wins: err_sticky=1, err_cnt=1.
- Pulse width:
  - wrap_pulse, restart_pulse and err_pulse are high for exactly one cycle.
  - They are mutually exclusive.
- Reset mid-operation:
  - rst overrides everything.
  - After release, locked=0 for at least LOCK_LEN+1 cycles.

Test Plan:
- Basic lock and wraps:
  - Stimulus: rst for 5 clocks, then an up counter free-running from 0, dir=0.
  - Response: locked=1 by the 4th edge after release. wrap_pulse fires on each 15→0. wrap_cnt=2 after 32 further cycles. err_cnt=0.
- Restart:
  - Stimulus: while locked, counter reset to 0 at count 9.
  - Response: restart_pulse=1 for 1 cycle, locked drops, relocks after 0→1→2. err_sticky=0.
- Hold and skip errors:
  - Stimulus: hold count at 5 for 2 cycles; later force 7→10.
  - Response: err_pulse each time, err_cnt=2, err_sticky=1, locked drops then relocks.
- Down mode:
  - Stimulus: dir=1, counter counts down 3,2,1,0,15,14.
  - Response: after lock, wrap_pulse on the 0→15 step and wrap_cnt increments. Toggling dir mid-run causes relock without error.
- Saturation and clear:
  - Stimulus: inject 20 errors.
  - Response: err_cnt=15 (saturated). A clr_err pulse gives err_cnt=0 and err_sticky=0. clr_err coincident with an error gives err_cnt=1.
- Reset mid-operation:
  - Stimulus: assert rst while locked with wrap_cnt=3.
  - Response: all outputs 0 on the next edge. No pulses during or right after reset.
